// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush > stall > load > bubble priority
module if_id_reg #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;
  logic            w_load;
  assign w_load = i_load && !i_flush && !i_stall;
  // bubbles keep PCD/PCPlus4D so only InstrD/ValidD change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush || !i_stall) begin
      r_instr <= w_load ? i_instr : NOP_INSTR;
      r_valid <= w_load;
      if (w_load) begin
        r_pc       <= i_pc;
        r_pc_plus4 <= i_pc + XLEN'(4);
      end
    end
  end
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC, one-outstanding imem request FSM with hold buffer and
// redirect kill, feeding the IF/ID register
module fetch_stage #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReqValid,
  output logic [XLEN-1:0] ImemReqAddr,
  input  logic            ImemReqReady,
  input  logic            ImemRspValid,
  input  logic [31:0]     ImemRspData,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  import riscv_pkg::*;
  fetch_state_t    r_state, w_next;
  logic [XLEN-1:0] r_pcf;
  logic            r_kill, w_kill_next;
  logic [31:0]     r_hold_instr;
  logic [XLEN-1:0] r_hold_pc;
  logic            w_is_wait, w_is_hold, w_rsp, w_avail, w_deliver, w_capture;
  logic [31:0]     w_instr;
  logic [XLEN-1:0] w_pc;
  assign w_is_wait = r_state == S_WAIT;
  assign w_is_hold = r_state == S_HOLD;
  assign w_rsp     = w_is_wait && ImemRspValid;
  assign w_avail   = (w_rsp && !r_kill) || w_is_hold;
  assign w_instr   = w_is_hold ? r_hold_instr : ImemRspData;
  assign w_pc      = w_is_hold ? r_hold_pc : r_pcf;
  assign w_deliver = w_avail && !StallF && !StallD && !PCSrcE;
  assign w_capture = w_rsp && !r_kill && !PCSrcE && !w_deliver;
  always_comb begin
    w_next      = r_state;
    w_kill_next = r_kill;
    case (r_state)
      S_REQ: if (ImemReqReady) begin
        w_next      = S_WAIT;
        w_kill_next = PCSrcE;
      end
      S_WAIT: if (w_rsp) begin
        w_next      = (w_deliver || PCSrcE || r_kill) ? S_REQ : S_HOLD;
        w_kill_next = 1'b0;
      end else if (PCSrcE) begin
        w_kill_next = 1'b1;
      end
      S_HOLD: w_next = (w_deliver || PCSrcE) ? S_REQ : S_HOLD;
      default: w_next = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pcf        <= RESET_PC;
      r_kill       <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      r_state <= w_next;
      r_kill  <= w_kill_next;
      r_pcf   <= PCSrcE ? PCTargetE : w_deliver ? r_pcf + XLEN'(4) : r_pcf;
      if (w_capture) begin
        r_hold_instr <= ImemRspData;
        r_hold_pc    <= r_pcf;
      end
    end
  end
  assign ImemReqValid = r_state == S_REQ;
  assign ImemReqAddr  = r_pcf;
  assign PCF          = r_pcf;
  if_id_reg #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (FlushD),
    .i_stall    (StallD),
    .i_load     (w_deliver),
    .i_instr    (w_instr),
    .i_pc       (w_pc),
    .o_instr    (InstrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a zero-wait imem model
// that returns addr>>2 and can be told to withhold its response
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReqValid, ImemReqReady, ImemRspValid, ValidD;
  logic [31:0] ImemReqAddr, ImemRspData, PCF, InstrD, PCD, PCPlus4D;
  logic        mem_pending, mem_hold;
  logic [31:0] mem_addr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .ImemReqValid (ImemReqValid),
    .ImemReqAddr  (ImemReqAddr),
    .ImemReqReady (ImemReqReady),
    .ImemRspValid (ImemRspValid),
    .ImemRspData  (ImemRspData),
    .PCF          (PCF),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .PCPlus4D     (PCPlus4D),
    .ValidD       (ValidD)
  );

  assign ImemRspValid = mem_pending && !mem_hold;
  assign ImemRspData  = mem_addr >> 2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pending <= 1'b0;
      mem_addr    <= '0;
    end else if (ImemReqValid && ImemReqReady) begin
      mem_pending <= 1'b1;
      mem_addr    <= ImemReqAddr;
    end else if (ImemRspValid) begin
      mem_pending <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; ImemReqReady = 1'b1; mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instr", InstrD, 32'h13);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_valid", ValidD, 1'b0);
    chk("rst_reqv", ImemReqValid, 1'b1);
    rst_n = 1'b1;
    step();
    chk("req0_accepted", ImemReqValid, 1'b0);
    step();
    chk("d0_instr", InstrD, 32'h0);
    chk("d0_valid", ValidD, 1'b1);
    chk("d0_pc4", PCPlus4D, 32'h4);
    chk("req4_valid", ImemReqValid, 1'b1);
    chk("req4_addr", ImemReqAddr, 32'h4);
    step();
    chk("gap_bubble", ValidD, 1'b0);
    step();
    chk("d1_instr", InstrD, 32'h1);
    chk("d1_pcd", PCD, 32'h4);
    chk("req8_addr", ImemReqAddr, 32'h8);
    StallF = 1'b1; StallD = 1'b1;
    step();
    chk("stall_c1_instr", InstrD, 32'h1);
    step();
    chk("stall_c2_instr", InstrD, 32'h1);
    chk("stall_c2_noreq", ImemReqValid, 1'b0);
    step();
    chk("stall_c3_instr", InstrD, 32'h1);
    chk("stall_c3_valid", ValidD, 1'b1);
    chk("stall_c3_noreq", ImemReqValid, 1'b0);
    chk("stall_c3_pcf", PCF, 32'h8);
    StallF = 1'b0; StallD = 1'b0;
    step();
    chk("held_instr", InstrD, 32'h2);
    chk("held_pcd", PCD, 32'h8);
    chk("held_valid", ValidD, 1'b1);
    chk("reqC_addr", ImemReqAddr, 32'hC);
    mem_hold = 1'b1;
    step();
    chk("waitC_noreq", ImemReqValid, 1'b0);
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    step();
    chk("redir_pcf", PCF, 32'h100);
    chk("redir_wait", ImemReqValid, 1'b0);
    PCSrcE = 1'b0; mem_hold = 1'b0;
    step();
    chk("killed_bubble", ValidD, 1'b0);
    chk("req100_valid", ImemReqValid, 1'b1);
    chk("req100_addr", ImemReqAddr, 32'h100);
    step();
    step();
    chk("d100_instr", InstrD, 32'h40);
    chk("d100_pcd", PCD, 32'h100);
    chk("d100_pc4", PCPlus4D, 32'h104);
    chk("d100_valid", ValidD, 1'b1);
    FlushD = 1'b1; StallD = 1'b1;
    step();
    chk("flush_instr", InstrD, 32'h13);
    chk("flush_valid", ValidD, 1'b0);
    chk("flush_pcd", PCD, 32'h100);
    FlushD = 1'b0; StallD = 1'b0;
    step();
    chk("d104_instr", InstrD, 32'h41);
    ImemReqReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nordy_reqv", ImemReqValid, 1'b1);
      chk("nordy_addr", ImemReqAddr, 32'h108);
      chk("nordy_bubble", ValidD, 1'b0);
    end
    ImemReqReady = 1'b1;
    step();
    step();
    chk("d108_instr", InstrD, 32'h42);
    ImemReqReady = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step();
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    ImemReqReady = 1'b1; PCSrcE = 1'b0;
    step();
    step();
    chk("wrap_instr", InstrD, 32'h3FFF_FFFF);
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4D, 32'h0);
    chk("wrap_next_pcf", PCF, 32'h0);
    StallD = 1'b1; mem_hold = 1'b1;
    step();
    chk("pre_rst_wait", ImemReqValid, 1'b0);
    chk("pre_rst_instr", InstrD, 32'h3FFF_FFFF);
    rst_n = 1'b0;
    #1;
    chk("arst_instr", InstrD, 32'h13);
    chk("arst_pcd", PCD, 32'h0);
    chk("arst_valid", ValidD, 1'b0);
    chk("arst_reqv", ImemReqValid, 1'b1);
    chk("arst_addr", ImemReqAddr, 32'h0);
    step();
    rst_n = 1'b1; StallD = 1'b0; mem_hold = 1'b0;
    step();
    step();
    chk("post_rst_instr", InstrD, 32'h0);
    chk("post_rst_valid", ValidD, 1'b1);
    chk("post_rst_pcf", PCF, 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 32-bit pipelined RISC-V core, directly upstream of the decode stage and the hazard unit. It owns the fetch PC and performs a valid/ready request/response exchange with instruction memory, allowing one request in flight. It applies the hazard unit's StallF/StallD/FlushD and the execute-stage redirect (PCSrcE/PCTargetE), then presents InstrD/PCD/PCPlus4D to decode.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- StallF  in  1  hold fetch PC (load-use stall)
- StallD  in  1  hold IF/ID register
- FlushD  in  1  replace IF/ID contents with a bubble
- PCSrcE  in  1  taken branch/jump in execute
- PCTargetE  in  XLEN  redirect target
- ImemReqValid  out  1  fetch request valid
- ImemReqAddr  out  XLEN  fetch address (= PCF)
- ImemReqReady  in  1  memory accepts request
- ImemRspValid  in  1  instruction word returned
- ImemRspData  in  32  returned instruction
- PCF  out  XLEN  current fetch PC
- InstrD  out  32  decode-stage instruction
- PCD  out  XLEN  PC of InstrD
- PCPlus4D  out  XLEN  PCD + 4
- ValidD  out  1  InstrD is a real instruction, not a bubble

## Operation
- FSM states:
  - S_REQ: ImemReqValid=1, ImemReqAddr=PCF. Request accepted when ImemReqReady=1; go to S_WAIT.
  - S_WAIT: await ImemRspValid.
  - S_HOLD: a fetched instruction sits in the one-entry hold buffer (instruction, PC).
- Kill flag: set when a redirect occurs in S_WAIT. The next response is discarded, the kill flag is cleared, and the FSM goes to S_REQ.
- Available instruction: either the ImemRspValid word in S_WAIT with kill=0, or the hold buffer in S_HOLD.
- Deliver when an instruction is available and StallF=0, StallD=0, PCSrcE=0. On deliver:
  - IF/ID is loaded with the instruction, its PC, and PC+4; ValidD=1.
  - PCF <= PCF+4.
  - FSM goes to S_REQ.
- Available but stalled: from S_WAIT, buffer the word and go to S_HOLD. In S_HOLD, remain there.
- Redirect (PCSrcE=1) has highest priority in every state:
  - PCF <= PCTargetE.
  - Any available instruction is dropped; the hold buffer is invalidated.
  - S_HOLD goes to S_REQ. S_WAIT without a same-cycle response sets kill and stays in S_WAIT. S_WAIT with a same-cycle response goes to S_REQ.
  - S_REQ: if the request is accepted the same cycle, it was for the old PC; set kill and go to S_WAIT.
- IF/ID update priority per edge:
  1. FlushD → bubble (InstrD=NOP_INSTR, ValidD=0; PCD and PCPlus4D unchanged).
  2. StallD → hold.
  3. Deliver → load.
  4. Otherwise → bubble.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. No alignment check; PCTargetE is used as given.
- Responses arriving in S_REQ or S_HOLD are protocol errors and are ignored.

## Timing
- Reset (asynchronous assert, synchronous-effect release) sets:
  - PCF=RESET_PC, state S_REQ, kill=0, hold buffer empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - ImemReqValid=1 in the first cycle after release.
- Reset mid-operation discards any outstanding request. The instruction memory shares rst_n.
- Latency, zero-wait memory:
  - Request in cycle n, response in n+1.
  - InstrD valid in cycle n+2.
  - Next request in n+2.
  - Peak throughput: one instruction per 2 cycles.
- ImemReqValid, once raised in S_REQ, stays high with a stable address until accepted, except on a redirect, where the address changes to PCTargetE.
- Redirect in cycle n: the request for PCTargetE is issued no later than the cycle after the killed response arrives.

## Structure
- Shared package riscv_pkg:
  - XLEN, NOP_INSTR, RESET_PC defaults.
  - fetch_state_t enum {S_REQ, S_WAIT, S_HOLD}.
- Sub-module if_id_reg: the IF/ID register with flush/stall/load/bubble priority. The FSM, PC, hold buffer and kill flag stay in fetch_stage.

## Test plan
- Reset release with zero-wait memory returning addr>>2 as data → requests at 0x0, 0x4, 0x8. InstrD=0x0 with ValidD=1 two cycles after the first request; PCPlus4D=0x4.
- StallF=StallD=1 for 3 cycles while the response for 0x8 arrives → InstrD held, FSM in S_HOLD, no new request. The buffered 0x8 instruction is delivered the cycle after the stall drops.
- PCSrcE=1, PCTargetE=0x100 while in S_WAIT for 0xC → the 0xC response is discarded. The next request address is 0x100, and the next ValidD=1 carries PCD=0x100.
- FlushD=1 and StallD=1 in the same cycle → InstrD=0x0000_0013, ValidD=0.
- ImemReqReady held low for 4 cycles → ImemReqValid=1 with a stable address throughout; IF/ID shows bubbles (ValidD=0).
- PCF=0xFFFF_FFFC delivered → next PCF=0x0000_0000, PCPlus4D=0x0000_0000. rst_n pulsed low mid-S_WAIT → immediate reset values, with the next request at RESET_PC.
